red_pitaya_dfilt_mc: RTL and testbench
======================================

# red_pitaya_dfilt_mc

Multi-channel, parametrised successor to the single-channel ADC equalisation filter. It sits between the ADC input registers and the acquisition/scope path. Each of `CHN` channels runs an independent pole/zero equaliser, a first-order pole and an output gain stage with saturation. Coefficients are double-buffered so that all channels switch atomically. The block accepts a sample-valid strobe, so it also runs on decimated streams, and it adds per-channel bypass, a filter-state clear and sticky saturation flags.

## Interface

Parameters:
- `CHN`, default 2: number of channels, range 1..8.
- `DW`, default 14: sample width, signed two's complement.
- `CW`, default `max($clog2(CHN),1)`: channel-select width.

Ports (clock and reset first):
- `adc_clk_i`  in  1  sample clock; the only clock.
- `adc_rst_i`  in  1  reset, synchronous, active-high.
- `adc_vld_i`  in  1  input sample valid, common to all channels.
- `adc_dat_i`  in  CHN*DW  packed samples; channel c occupies `[c*DW +: DW]`.
- `adc_vld_o`  out  1  output sample valid.
- `adc_dat_o`  out  CHN*DW  packed filtered samples.
- `cfg_we_i`  in  1  write the `cfg_*` values into the shadow set of channel `cfg_chn_i`.
- `cfg_chn_i`  in  CW  target channel; writes to channels ≥ CHN are ignored.
- `cfg_aa_i`  in  18  pole coefficient A, unsigned.
- `cfg_bb_i`  in  25  zero gain B, unsigned.
- `cfg_pp_i`  in  25  second pole P, unsigned.
- `cfg_kk_i`  in  25  output gain K, unsigned.
- `cfg_byp_i`  in  1  bypass enable for the channel.
- `cfg_commit_i`  in  1  pulse: copy every shadow set to the active set.
- `cfg_clr_i`  in  1  pulse: zero the filter state of all channels.
- `sat_clr_i`  in  1  clear all sticky saturation flags.
- `sat_o`  out  CHN  sticky per-channel saturation flags.

## Operation

Per channel, with x a signed DW-bit sample, per valid sample n:
- Difference: e[n] = x[n] − x[n−1], DW+1 bits.
- First pole/zero stage, y1 held as 48-bit signed:
  - y1[n] = y1[n−1] − ((A·y1[n−1]) >>> 18) + B·e[n].
  - Arithmetic shift; result wraps in 48 bits.
- Second pole, y2 held as 48-bit signed:
  - y2[n] = y2[n−1] + ((P·(y1[n] − y2[n−1])) >>> 24).
  - The difference term is 49 bits.
- Output: o[n] = sat_DW((K·y2[n]) >>> 40).
  - sat_DW clamps to the range [−2^(DW−1), 2^(DW−1)−1].
- Identity configuration: A=0, B=65536, P=16777216, K=16777216 gives o[n] = x[n].

State handling:
- x_prev, y1 and y2 update only when their stage holds a valid sample; gaps in `adc_vld_i` freeze the state.
- Bypass: o[n] = x[n], with the same latency and the same `adc_vld_o`. The filter state keeps updating, so leaving bypass is seamless.
- `sat_o[c]` is set on the cycle channel c presents a clamped valid output; bypass never saturates.
- `sat_clr_i` clears `sat_o`. If clear and set occur in the same cycle, set wins.

Coefficient buffering:
- `cfg_we_i` writes the shadow set only. The active set is untouched until `cfg_commit_i`.
- On the commit edge, all channels' active sets load their shadows simultaneously.
- A `cfg_we_i` in the same cycle as `cfg_commit_i` is forwarded, so the written channel commits the new values.
- Samples already in flight use the new coefficients in their remaining stages. This mixing is accepted and documented.

State clear:
- `cfg_clr_i` zeroes x_prev, y1 and y2 of all channels.
- It does not alter the pipeline valids or the coefficients.
- If a stage update coincides with `cfg_clr_i`, the clear wins.

Reset (`adc_rst_i`=1 at a clock edge):
- `adc_vld_o`=0, `adc_dat_o`=0, `sat_o`=0.
- All filter state = 0; in-flight valids are dropped.
- Shadow and active sets: A=B=P=K=0, bypass=1.
- Reset mid-stream behaves identically. The first output after release belongs to a sample accepted after release.

## Timing

Pipeline, 4 stages, each advancing with its own valid bit:
- S1: register x and e.
- S2: update y1.
- S3: update y2.
- S4: multiply by K, saturate, register the output.

Cycle-level behaviour:
- Latency: `adc_vld_i` at edge t gives `adc_vld_o`=1 in the cycle after edge t+3, i.e. 4 cycles.
- Throughput: one sample per clock per channel; back-to-back valids are supported.
- Commit and clear take effect at the edge where they are sampled.

Multiplier widths:
- A·y1: 66-bit product.
- P·diff: 74-bit product.
- K·y2: 73-bit product.
- The y1 recursion closes within one cycle.

## Test plan

1. **Identity.** Commit the identity configuration with bypass=0, then stream 1000, −2000, 8191, −8192 → `adc_dat_o` shows the same values, each 4 cycles later; `sat_o`=0.
2. **Decay.** Set A=131072 and the identity B/P/K. Drive a step 0→1000 held → output sequence 1000, 500, 250, 125, … (e is zero after the step).
3. **Saturation.** Set K=33554431 with the other identity values. Input 6000 → output 8191 and `sat_o[c]`=1. Input −6000 → output −8192. Pulse `sat_clr_i` → flag cleared. Clear coinciding with a new clamp → flag stays 1.
4. **Atomic commit.** Write different gains for ch0 (K=2^23) and ch1 (K=2^24) without commit → outputs unchanged. Commit → both channels change on the same output sample. A write to channel 5 with CHN=2 has no effect.
5. **Bypass and gaps.** Set bypass=1 and drive valid in the pattern 1,0,0,1,1 → `adc_vld_o` reproduces the pattern delayed by 4, with data equal to the inputs.
6. **Reset and clear.** Assert `adc_rst_i` mid-stream for 1 cycle → `adc_vld_o`=0 next cycle, outputs 0, bypass active. Under the decay configuration, pulse `cfg_clr_i` → the next output equals the new input sample (for example 300 after a 0 sample).

Source files
------------

// File: rtl/red_pitaya_dfilt_mc.sv
// rtl/red_pitaya_dfilt_mc.sv - multi-channel ADC pole/zero equaliser with double-buffered coefficients
module red_pitaya_dfilt_mc #(
    parameter int CHN = 2,
    parameter int DW  = 14,
    parameter int CW  = (CHN > 1) ? $clog2(CHN) : 1
) (
    input  logic              adc_clk_i,
    input  logic              adc_rst_i,
    input  logic              adc_vld_i,
    input  logic [CHN*DW-1:0] adc_dat_i,
    output logic              adc_vld_o,
    output logic [CHN*DW-1:0] adc_dat_o,
    input  logic              cfg_we_i,
    input  logic [CW-1:0]     cfg_chn_i,
    input  logic [17:0]       cfg_aa_i,
    input  logic [24:0]       cfg_bb_i,
    input  logic [24:0]       cfg_pp_i,
    input  logic [24:0]       cfg_kk_i,
    input  logic              cfg_byp_i,
    input  logic              cfg_commit_i,
    input  logic              cfg_clr_i,
    input  logic              sat_clr_i,
    output logic [CHN-1:0]    sat_o
);

    typedef struct packed {
        logic [17:0] aa;
        logic [24:0] bb;
        logic [24:0] pp;
        logic [24:0] kk;
        logic        byp;
    } coef_t;

    localparam coef_t COEF_RST = '{aa: '0, bb: '0, pp: '0, kk: '0, byp: 1'b1};

    // Coefficient sets: shadow is written by software, active feeds the datapath
    coef_t sh_q  [CHN];
    coef_t sh_d  [CHN];
    coef_t act_q [CHN];
    coef_t act_d [CHN];

    // Per-channel pipeline registers; x is carried alongside so bypass keeps the filter latency
    logic signed [DW-1:0] xprev_q [CHN];
    logic signed [DW-1:0] xprev_d [CHN];
    logic signed [DW-1:0] x1_q    [CHN];
    logic signed [DW-1:0] x1_d    [CHN];
    logic signed [DW:0]   e1_q    [CHN];
    logic signed [DW:0]   e1_d    [CHN];
    logic signed [DW-1:0] x2_q    [CHN];
    logic signed [DW-1:0] x2_d    [CHN];
    logic signed [47:0]   y1_q    [CHN];
    logic signed [47:0]   y1_d    [CHN];
    logic signed [DW-1:0] x3_q    [CHN];
    logic signed [DW-1:0] x3_d    [CHN];
    logic signed [47:0]   y2_q    [CHN];
    logic signed [47:0]   y2_d    [CHN];
    logic signed [DW-1:0] out_q   [CHN];
    logic signed [DW-1:0] out_d   [CHN];
    logic        [DW:0]   gain    [CHN];

    logic           vld1_q, vld1_d;
    logic           vld2_q, vld2_d;
    logic           vld3_q, vld3_d;
    logic           vldo_q, vldo_d;
    logic [CHN-1:0] sat_q, sat_d;

    // y1 - (A*y1 >>> 18) + B*e, everything wrapping in 48 bits
    function automatic logic signed [47:0] pole_zero(input logic signed [47:0] y1,
                                                     input logic [17:0] aa,
                                                     input logic [24:0] bb,
                                                     input logic signed [DW:0] e);
        return y1 - 48'(($signed({48'd0, aa}) * $signed({{18{y1[47]}}, y1})) >>> 18)
                  + 48'($signed({23'd0, bb}) * $signed({{(47-DW){e[DW]}}, e}));
    endfunction

    // y2 + (P*(y1 - y2) >>> 24) with a 49-bit difference term
    function automatic logic signed [47:0] second_pole(input logic signed [47:0] y1,
                                                       input logic signed [47:0] y2,
                                                       input logic [24:0] pp);
        logic signed [48:0] dd;
        dd = {y1[47], y1} - {y2[47], y2};
        return y2 + 48'(($signed({49'd0, pp}) * $signed({{25{dd[48]}}, dd})) >>> 24);
    endfunction

    // (K*y2 >>> 40) clamped to DW bits; the MSB of the result flags a clamp
    function automatic logic [DW:0] out_gain(input logic signed [47:0] y2,
                                             input logic [24:0] kk);
        logic signed [72:0] shr;
        logic [73-DW:0]     hi;
        shr = 73'(($signed({48'd0, kk}) * $signed({{25{y2[47]}}, y2})) >>> 40);
        hi  = shr[72:DW-1];
        if ((&hi) || (~|hi)) return {1'b0, shr[DW-1:0]};
        else if (shr[72])    return {1'b1, 1'b1, {(DW-1){1'b0}}};
        else                 return {1'b1, 1'b0, {(DW-1){1'b1}}};
    endfunction

    // Next-state logic: coefficient buffering, four valid-gated stages, state clear, sticky flags
    always_comb begin
        vld1_d = adc_vld_i;
        vld2_d = vld1_q;
        vld3_d = vld2_q;
        vldo_d = vld3_q;
        sat_d  = sat_clr_i ? '0 : sat_q;
        for (int c = 0; c < CHN; c++) begin
            sh_d[c] = sh_q[c];
            if (cfg_we_i && (int'(cfg_chn_i) == c)) begin
                sh_d[c] = '{aa: cfg_aa_i, bb: cfg_bb_i, pp: cfg_pp_i, kk: cfg_kk_i, byp: cfg_byp_i};
            end
            // commit takes sh_d so a same-cycle write lands in the active set too
            act_d[c] = cfg_commit_i ? sh_d[c] : act_q[c];

            xprev_d[c] = xprev_q[c];
            x1_d[c]    = x1_q[c];
            e1_d[c]    = e1_q[c];
            if (adc_vld_i) begin
                x1_d[c]    = adc_dat_i[c*DW +: DW];
                e1_d[c]    = {adc_dat_i[c*DW+DW-1], adc_dat_i[c*DW +: DW]} - {xprev_q[c][DW-1], xprev_q[c]};
                xprev_d[c] = adc_dat_i[c*DW +: DW];
            end

            y1_d[c] = y1_q[c];
            x2_d[c] = x2_q[c];
            if (vld1_q) begin
                y1_d[c] = pole_zero(y1_q[c], act_q[c].aa, act_q[c].bb, e1_q[c]);
                x2_d[c] = x1_q[c];
            end

            y2_d[c] = y2_q[c];
            x3_d[c] = x3_q[c];
            if (vld2_q) begin
                y2_d[c] = second_pole(y1_q[c], y2_q[c], act_q[c].pp);
                x3_d[c] = x2_q[c];
            end

            gain[c]  = out_gain(y2_q[c], act_q[c].kk);
            out_d[c] = out_q[c];
            if (vld3_q) begin
                if (act_q[c].byp) begin
                    out_d[c] = x3_q[c];
                end else begin
                    out_d[c] = gain[c][DW-1:0];
                    // a new clamp overrides a simultaneous clear
                    sat_d[c] = sat_d[c] | gain[c][DW];
                end
            end

            if (cfg_clr_i) begin
                xprev_d[c] = '0;
                y1_d[c]    = '0;
                y2_d[c]    = '0;
            end
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            vld1_q <= 1'b0;
            vld2_q <= 1'b0;
            vld3_q <= 1'b0;
            vldo_q <= 1'b0;
            sat_q  <= '0;
            for (int c = 0; c < CHN; c++) begin
                sh_q[c]    <= COEF_RST;
                act_q[c]   <= COEF_RST;
                xprev_q[c] <= '0;
                x1_q[c]    <= '0;
                e1_q[c]    <= '0;
                x2_q[c]    <= '0;
                y1_q[c]    <= '0;
                x3_q[c]    <= '0;
                y2_q[c]    <= '0;
                out_q[c]   <= '0;
            end
        end else begin
            vld1_q <= vld1_d;
            vld2_q <= vld2_d;
            vld3_q <= vld3_d;
            vldo_q <= vldo_d;
            sat_q  <= sat_d;
            for (int c = 0; c < CHN; c++) begin
                sh_q[c]    <= sh_d[c];
                act_q[c]   <= act_d[c];
                xprev_q[c] <= xprev_d[c];
                x1_q[c]    <= x1_d[c];
                e1_q[c]    <= e1_d[c];
                x2_q[c]    <= x2_d[c];
                y1_q[c]    <= y1_d[c];
                x3_q[c]    <= x3_d[c];
                y2_q[c]    <= y2_d[c];
                out_q[c]   <= out_d[c];
            end
        end
    end

    // Pack the registered per-channel outputs
    always_comb begin
        adc_dat_o = '0;
        for (int c = 0; c < CHN; c++) begin
            adc_dat_o[c*DW +: DW] = out_q[c];
        end
    end

    assign adc_vld_o = vldo_q;
    assign sat_o     = sat_q;

endmodule

// File: tb/tb_red_pitaya_dfilt_mc.sv
// tb/tb_red_pitaya_dfilt_mc.sv - directed self-checking bench for red_pitaya_dfilt_mc
module tb_red_pitaya_dfilt_mc;

    localparam int CHN   = 2;
    localparam int DW    = 14;
    localparam int CW    = 3;
    localparam int ID_B  = 65536;
    localparam int ID_P  = 16777216;
    localparam int ID_K  = 16777216;
    localparam int K_MAX = 33554431;

    logic              clk = 1'b0;
    logic              adc_rst = 1'b1;
    logic              adc_vld_i = 1'b0;
    logic [CHN*DW-1:0] adc_dat_i = '0;
    logic              adc_vld_o;
    logic [CHN*DW-1:0] adc_dat_o;
    logic              cfg_we = 1'b0;
    logic [CW-1:0]     cfg_chn = '0;
    logic [17:0]       cfg_aa = '0;
    logic [24:0]       cfg_bb = '0;
    logic [24:0]       cfg_pp = '0;
    logic [24:0]       cfg_kk = '0;
    logic              cfg_byp = 1'b0;
    logic              cfg_commit = 1'b0;
    logic              cfg_clr = 1'b0;
    logic              sat_clr = 1'b0;
    logic [CHN-1:0]    sat_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    red_pitaya_dfilt_mc #(.CHN(CHN), .DW(DW), .CW(CW)) dut (
        .adc_clk_i    (clk),
        .adc_rst_i    (adc_rst),
        .adc_vld_i    (adc_vld_i),
        .adc_dat_i    (adc_dat_i),
        .adc_vld_o    (adc_vld_o),
        .adc_dat_o    (adc_dat_o),
        .cfg_we_i     (cfg_we),
        .cfg_chn_i    (cfg_chn),
        .cfg_aa_i     (cfg_aa),
        .cfg_bb_i     (cfg_bb),
        .cfg_pp_i     (cfg_pp),
        .cfg_kk_i     (cfg_kk),
        .cfg_byp_i    (cfg_byp),
        .cfg_commit_i (cfg_commit),
        .cfg_clr_i    (cfg_clr),
        .sat_clr_i    (sat_clr),
        .sat_o        (sat_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int x0, input int x1, input logic v);
        adc_dat_i = {14'(x1), 14'(x0)};
        adc_vld_i = v;
    endtask

    task automatic wr(input int chn, input int a, input int b, input int p, input int k, input logic byp);
        cfg_we  = 1'b1;
        cfg_chn = 3'(chn);
        cfg_aa  = 18'(a);
        cfg_bb  = 25'(b);
        cfg_pp  = 25'(p);
        cfg_kk  = 25'(k);
        cfg_byp = byp;
        tick();
        cfg_we  = 1'b0;
    endtask

    task automatic cfg_all(input int a, input int b, input int p, input int k, input logic byp);
        wr(0, a, b, p, k, byp);
        wr(1, a, b, p, k, byp);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        cfg_clr = 1'b1;
        tick();
        cfg_clr = 1'b0;
    endtask

    // Sample at edge t, idle through t+2; the caller's next tick is edge t+3
    task automatic shoot(input int x0, input int x1);
        drive(x0, x1, 1'b1);
        tick();
        drive(0, 0, 1'b0);
        tick();
        tick();
    endtask

    task automatic test_reset();
        logic [27:0] exp;
        adc_rst = 1'b1;
        drive(5, 5, 1'b1);
        tick();
        tick();
        adc_rst = 1'b0;
        drive(0, 0, 1'b0);
        total_cnt++; if (adc_vld_o !== 1'b0) $display("FAIL rst_vld: got %b want 0", adc_vld_o); else pass_cnt++;
        total_cnt++; if (adc_dat_o !== 28'd0) $display("FAIL rst_dat: got %h want 0", adc_dat_o); else pass_cnt++;
        total_cnt++; if (sat_o !== 2'b00) $display("FAIL rst_sat: got %b want 00", sat_o); else pass_cnt++;
        shoot(123, -45);
        total_cnt++; if (adc_vld_o !== 1'b0) $display("FAIL rst_latency_early: got %b want 0", adc_vld_o); else pass_cnt++;
        tick();
        exp = {14'(-45), 14'(123)};
        total_cnt++; if (adc_vld_o !== 1'b1) $display("FAIL rst_latency_vld: got %b want 1", adc_vld_o); else pass_cnt++;
        total_cnt++; if (adc_dat_o !== exp) $display("FAIL rst_bypass_dat: got %h want %h", adc_dat_o, exp); else pass_cnt++;
        tick();
        total_cnt++; if (adc_vld_o !== 1'b0) $display("FAIL rst_vld_drop: got %b want 0", adc_vld_o); else pass_cnt++;
    endtask

    task automatic test_identity();
        int v0 [4] = '{1000, -2000, 8191, -8192};
        int v1 [4] = '{-8192, 8191, -2000, 1000};
        logic [27:0] exp;
        cfg_all(0, ID_B, ID_P, ID_K, 1'b0);
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(v0[i], v1[i], 1'b1); else drive(0, 0, 1'b0);
            tick();
            if (i == 2) begin
                total_cnt++; if (adc_vld_o !== 1'b0) $display("FAIL id_vld_early: got %b want 0", adc_vld_o); else pass_cnt++;
            end
            if (i >= 3) begin
                exp = {14'(v1[i-3]), 14'(v0[i-3])};
                total_cnt++; if (adc_vld_o !== 1'b1) $display("FAIL id_vld[%0d]: got %b want 1", i-3, adc_vld_o); else pass_cnt++;
                total_cnt++; if (adc_dat_o !== exp) $display("FAIL id_dat[%0d]: got %h want %h", i-3, adc_dat_o, exp); else pass_cnt++;
            end
        end
        total_cnt++; if (sat_o !== 2'b00) $display("FAIL id_sat: got %b want 00", sat_o); else pass_cnt++;
    endtask

    task automatic test_saturation();
        logic [27:0] exp;
        cfg_all(0, ID_B, ID_P, K_MAX, 1'b0);
        shoot(6000, 100);
        tick();
        exp = {14'(199), 14'(8191)};
        total_cnt++; if (adc_dat_o !== exp) $display("FAIL sat_pos_dat: got %h want %h", adc_dat_o, exp); else pass_cnt++;
        total_cnt++; if (sat_o !== 2'b01) $display("FAIL sat_pos_flag: got %b want 01", sat_o); else pass_cnt++;
        shoot(-6000, 100);
        tick();
        exp = {14'(199), 14'(-8192)};
        total_cnt++; if (adc_dat_o !== exp) $display("FAIL sat_neg_dat: got %h want %h", adc_dat_o, exp); else pass_cnt++;
        total_cnt++; if (sat_o !== 2'b01) $display("FAIL sat_neg_flag: got %b want 01", sat_o); else pass_cnt++;
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        total_cnt++; if (sat_o !== 2'b00) $display("FAIL sat_clear: got %b want 00", sat_o); else pass_cnt++;
        shoot(6000, 100);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        exp = {14'(199), 14'(8191)};
        total_cnt++; if (sat_o !== 2'b01) $display("FAIL sat_set_wins: got %b want 01", sat_o); else pass_cnt++;
        total_cnt++; if (adc_dat_o !== exp) $display("FAIL sat_set_wins_dat: got %h want %h", adc_dat_o, exp); else pass_cnt++;
    endtask

    task automatic test_commit();
        logic [27:0] exp;
        wr(0, 0, ID_B, ID_P, 1 << 23, 1'b0);
        wr(1, 0, ID_B, ID_P, ID_K, 1'b0);
        wr(5, 0, ID_B, ID_P, 0, 1'b0);
        shoot(1000, 2000);
        tick();
        exp = {14'(3999), 14'(1999)};
        total_cnt++; if (adc_dat_o !== exp) $display("FAIL commit_shadow_only: got %h want %h", adc_dat_o, exp); else pass_cnt++;
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        shoot(1000, 2000);
        tick();
        exp = {14'(2000), 14'(500)};
        total_cnt++; if (adc_dat_o !== exp) $display("FAIL commit_atomic: got %h want %h", adc_dat_o, exp); else pass_cnt++;
    endtask

    task automatic test_bypass_gaps();
        int   b0 [5] = '{8000, 1, 3, -123, 4321};
        int   b1 [5] = '{-8000, 2, 4, 456, -1234};
        logic pv [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic ev;
        logic [27:0] exp;
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        cfg_all(0, ID_B, ID_P, K_MAX, 1'b1);
        for (int i = 0; i < 9; i++) begin
            if (i < 5) drive(b0[i], b1[i], pv[i]); else drive(0, 0, 1'b0);
            tick();
            if (i >= 3) begin
                ev = (i - 3 < 5) ? pv[i-3] : 1'b0;
                total_cnt++; if (adc_vld_o !== ev) $display("FAIL byp_vld[%0d]: got %b want %b", i-3, adc_vld_o, ev); else pass_cnt++;
                if (ev) begin
                    exp = {14'(b1[i-3]), 14'(b0[i-3])};
                    total_cnt++; if (adc_dat_o !== exp) $display("FAIL byp_dat[%0d]: got %h want %h", i-3, adc_dat_o, exp); else pass_cnt++;
                end
            end
        end
        total_cnt++; if (sat_o !== 2'b00) $display("FAIL byp_sat: got %b want 00", sat_o); else pass_cnt++;
    endtask

    task automatic test_decay();
        int d [6] = '{1000, 500, 250, 125, 62, 31};
        logic [27:0] exp;
        cfg_all(131072, ID_B, ID_P, ID_K, 1'b0);
        for (int i = 0; i < 9; i++) begin
            if (i < 6) drive(1000, 0, 1'b1); else drive(0, 0, 1'b0);
            tick();
            if (i >= 3) begin
                exp = {14'(0), 14'(d[i-3])};
                total_cnt++; if (adc_vld_o !== 1'b1) $display("FAIL decay_vld[%0d]: got %b want 1", i-3, adc_vld_o); else pass_cnt++;
                total_cnt++; if (adc_dat_o !== exp) $display("FAIL decay_dat[%0d]: got %h want %h", i-3, adc_dat_o, exp); else pass_cnt++;
            end
        end
    endtask

    task automatic test_clear();
        logic [27:0] exp;
        cfg_clr = 1'b1;
        tick();
        cfg_clr = 1'b0;
        shoot(300, 0);
        tick();
        exp = {14'(0), 14'(300)};
        total_cnt++; if (adc_dat_o !== exp) $display("FAIL clr_first: got %h want %h", adc_dat_o, exp); else pass_cnt++;
        shoot(300, 0);
        tick();
        exp = {14'(0), 14'(150)};
        total_cnt++; if (adc_dat_o !== exp) $display("FAIL clr_coef_kept: got %h want %h", adc_dat_o, exp); else pass_cnt++;
    endtask

    task automatic test_reset_midstream();
        logic [27:0] exp;
        for (int i = 0; i < 3; i++) begin
            drive(500, -500, 1'b1);
            tick();
        end
        adc_rst = 1'b1;
        tick();
        adc_rst = 1'b0;
        drive(0, 0, 1'b0);
        total_cnt++; if (adc_vld_o !== 1'b0) $display("FAIL mid_rst_vld: got %b want 0", adc_vld_o); else pass_cnt++;
        total_cnt++; if (adc_dat_o !== 28'd0) $display("FAIL mid_rst_dat: got %h want 0", adc_dat_o); else pass_cnt++;
        total_cnt++; if (sat_o !== 2'b00) $display("FAIL mid_rst_sat: got %b want 00", sat_o); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            tick();
            total_cnt++; if (adc_vld_o !== 1'b0) $display("FAIL mid_rst_drop[%0d]: got %b want 0", i, adc_vld_o); else pass_cnt++;
        end
        shoot(77, -77);
        tick();
        exp = {14'(-77), 14'(77)};
        total_cnt++; if (adc_vld_o !== 1'b1) $display("FAIL mid_rst_new_vld: got %b want 1", adc_vld_o); else pass_cnt++;
        total_cnt++; if (adc_dat_o !== exp) $display("FAIL mid_rst_bypass: got %h want %h", adc_dat_o, exp); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_saturation();
        test_commit();
        test_bypass_gaps();
        test_decay();
        test_clear();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
